// File: rtl/wrr_sched_pkg.sv
// -----------------------------------------------------------------------------
// wrr_sched_pkg
// Shared definitions for the weighted round-robin packet scheduler:
//   - default queue count and field widths used as parameter defaults
//   - FSM state encoding used by wrr_sched
// No ports (package).
// -----------------------------------------------------------------------------
package wrr_sched_pkg;

    localparam int WRR_NUM_Q        = 8;
    localparam int WRR_PRIORITY_BIT = 3;
    localparam int WRR_WEIGHT_BIT   = 4;
    localparam int WRR_DEF_WEIGHT   = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARB       = 2'd1,
        GRANT     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/wrr_sched_pick.sv
// -----------------------------------------------------------------------------
// wrr_pick
// Combinational rotating find-first: returns the first set bit of 'eligible'
// found by searching upward from 'ptr', wrapping from NUM_Q-1 back to 0.
// Ports:
//   eligible  in   NUM_Q         candidate queues
//   ptr       in   PRIORITY_BIT  search start position
//   hit       out  1             at least one candidate found
//   qid       out  PRIORITY_BIT  winning queue id (0 when no hit)
// -----------------------------------------------------------------------------
module wrr_pick
    import wrr_sched_pkg::*;
#(
    parameter int NUM_Q        = WRR_NUM_Q,
    parameter int PRIORITY_BIT = WRR_PRIORITY_BIT
) (
    input  logic [NUM_Q-1:0]        eligible,
    input  logic [PRIORITY_BIT-1:0] ptr,
    output logic                    hit,
    output logic [PRIORITY_BIT-1:0] qid
);

    logic [PRIORITY_BIT-1:0] idx;

    always_comb begin
        hit = 1'b0;
        qid = '0;
        idx = '0;
        for (int k = 0; k < NUM_Q; k++) begin
            // NUM_Q is a power of two, so the adder wraps for free
            idx = ptr + PRIORITY_BIT'(k);
            if (!hit && eligible[idx]) begin
                hit = 1'b1;
                qid = idx;
            end
        end
    end

endmodule

// File: rtl/wrr_sched.sv
// -----------------------------------------------------------------------------
// wrr_sched
// Weighted round-robin packet scheduler for NUM_Q priority queues. Issues one
// grant per packet, waits for pkt_done, then arbitrates again. Each queue
// spends one credit per granted packet; when no queue with data has credit
// left, all credits are reloaded from the run-time configurable weights.
//
// Optional feature: define WRR_STRICT_TOP_EN to make queue NUM_Q-1 strict
// priority (it wins whenever it has data and a non-zero weight, and never
// touches credits or the round-robin pointer).
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   q_nempty     per-queue "holds a complete packet" flags
//   cfg_we       weight write strobe, cfg_qid/cfg_weight select queue/value
//   grant_vld    grant offered, grant_qid = granted queue
//   grant_rdy    sink accepts the grant (accept = grant_vld & grant_rdy)
//   pkt_done     one-cycle pulse: granted packet fully sent
//   busy         scheduler not idle
// -----------------------------------------------------------------------------
module wrr_sched
    import wrr_sched_pkg::*;
#(
    parameter int NUM_Q        = WRR_NUM_Q,
    parameter int PRIORITY_BIT = WRR_PRIORITY_BIT,
    parameter int WEIGHT_BIT   = WRR_WEIGHT_BIT,
    parameter int DEF_WEIGHT   = WRR_DEF_WEIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_Q-1:0]        q_nempty,
    input  logic                    cfg_we,
    input  logic [PRIORITY_BIT-1:0] cfg_qid,
    input  logic [WEIGHT_BIT-1:0]   cfg_weight,
    output logic                    grant_vld,
    output logic [PRIORITY_BIT-1:0] grant_qid,
    input  logic                    grant_rdy,
    input  logic                    pkt_done,
    output logic                    busy
);

`ifdef WRR_STRICT_TOP_EN
    localparam bit STRICT_TOP = 1'b1;
`else
    localparam bit STRICT_TOP = 1'b0;
`endif

    localparam logic [PRIORITY_BIT-1:0] TOP_ID   = PRIORITY_BIT'(NUM_Q - 1);
    localparam logic [NUM_Q-1:0]        TOP_MASK = {1'b1, {(NUM_Q-1){1'b0}}};
    localparam logic [WEIGHT_BIT-1:0]   W_DEF    = WEIGHT_BIT'(DEF_WEIGHT);
    localparam logic [WEIGHT_BIT-1:0]   W_ONE    = WEIGHT_BIT'(1);

    state_t                  state;
    logic [WEIGHT_BIT-1:0]   weight [NUM_Q];
    logic [WEIGHT_BIT-1:0]   credit [NUM_Q];
    logic [PRIORITY_BIT-1:0] ptr;

    logic [NUM_Q-1:0]        live;
    logic [NUM_Q-1:0]        eligible;
    logic [NUM_Q-1:0]        wrr_live;
    logic [NUM_Q-1:0]        wrr_elig;
    logic                    pick_hit;
    logic [PRIORITY_BIT-1:0] pick_qid;
    logic                    top_strict_win;
    logic                    grant_is_top;

    always_comb begin
        live     = '0;
        eligible = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            live[i]     = q_nempty[i] && (weight[i] != '0);
            eligible[i] = live[i] && (credit[i] != '0);
        end
    end

    // With strict top enabled, the top queue takes no part in WRR picking
    // or in deciding whether a reload is due.
    assign wrr_live       = STRICT_TOP ? (live & ~TOP_MASK)     : live;
    assign wrr_elig       = STRICT_TOP ? (eligible & ~TOP_MASK) : eligible;
    assign top_strict_win = STRICT_TOP && live[NUM_Q-1];
    assign grant_is_top   = STRICT_TOP && (grant_qid == TOP_ID);
    assign busy           = (state != IDLE);

    wrr_pick #(
        .NUM_Q        (NUM_Q),
        .PRIORITY_BIT (PRIORITY_BIT)
    ) u_pick (
        .eligible (wrr_elig),
        .ptr      (ptr),
        .hit      (pick_hit),
        .qid      (pick_qid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            grant_vld <= 1'b0;
            grant_qid <= '0;
            ptr       <= '0;
            for (int i = 0; i < NUM_Q; i++) begin
                weight[i] <= W_DEF;
                credit[i] <= W_DEF;
            end
        end else begin
            if (cfg_we)
                weight[cfg_qid] <= cfg_weight;

            case (state)
                IDLE: begin
                    if (|live)
                        state <= ARB;
                end
                ARB: begin
                    if (top_strict_win) begin
                        grant_qid <= TOP_ID;
                        grant_vld <= 1'b1;
                        state     <= GRANT;
                    end else if (pick_hit) begin
                        grant_qid <= pick_qid;
                        grant_vld <= 1'b1;
                        state     <= GRANT;
                    end else if (|wrr_live) begin
                        // Round reload; a weight written this same cycle is
                        // taken directly so the new round already uses it.
                        for (int i = 0; i < NUM_Q; i++) begin
                            if (!(STRICT_TOP && (i == NUM_Q - 1))) begin
                                if (cfg_we && (cfg_qid == PRIORITY_BIT'(i)))
                                    credit[i] <= cfg_weight;
                                else
                                    credit[i] <= weight[i];
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (grant_rdy) begin
                        grant_vld <= 1'b0;
                        state     <= WAIT_DONE;
                        if (!grant_is_top) begin
                            credit[grant_qid] <= credit[grant_qid] - W_ONE;
                            // Last credit spent: move on to the next queue,
                            // otherwise stay so the queue keeps its turn.
                            if (credit[grant_qid] == W_ONE)
                                ptr <= grant_qid + PRIORITY_BIT'(1);
                            else
                                ptr <= grant_qid;
                        end
                    end
                end
                WAIT_DONE: begin
                    // Pass straight through IDLE when work is pending so a
                    // back-to-back grant follows pkt_done by two cycles.
                    if (pkt_done)
                        state <= (|live) ? ARB : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wrr_sched.sv
// -----------------------------------------------------------------------------
// tb_wrr_sched
// Self-checking bench for wrr_sched: a per-cycle vector table for basic
// latency/rotation/reload, plus directed sequences for weighting, grant hold,
// run-time weight changes and mid-operation reset. Inputs change 1 ns after
// the rising edge and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_wrr_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] q_nempty = '0;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_qid = '0;
    logic [3:0] cfg_weight = '0;
    logic       grant_vld;
    logic [2:0] grant_qid;
    logic       grant_rdy = 1'b1;
    logic       pkt_done = 1'b0;
    logic       busy;

    int npass  = 0;
    int ntotal = 0;

    wrr_sched dut (
        .clk        (clk),
        .rst        (rst),
        .q_nempty   (q_nempty),
        .cfg_we     (cfg_we),
        .cfg_qid    (cfg_qid),
        .cfg_weight (cfg_weight),
        .grant_vld  (grant_vld),
        .grant_qid  (grant_qid),
        .grant_rdy  (grant_rdy),
        .pkt_done   (pkt_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       rdy;
        logic       done;
        logic       exp_vld;
        logic [2:0] exp_qid;
        logic       exp_busy;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act === exp)
            npass++;
        else
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        q_nempty   = '0;
        cfg_we     = 1'b0;
        cfg_qid    = '0;
        cfg_weight = '0;
        grant_rdy  = 1'b1;
        pkt_done   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input string nm);
        int n;
        n = 0;
        while (grant_vld !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({nm, "_vld"}, grant_vld, 1);
    endtask

    // Wait for a grant, check its queue, accept it, finish the packet
    // three cycles after acceptance.
    task automatic serve(input int exp_q, input string nm);
        grant_rdy = 1'b1;
        wait_grant(nm);
        chk({nm, "_qid"}, grant_qid, exp_q);
        step();
        chk({nm, "_acc"}, grant_vld, 0);
        step();
        step();
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] q, input logic [3:0] w);
        cfg_we     = 1'b1;
        cfg_qid    = q;
        cfg_weight = w;
        step();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        //           q      rdy   done  vld   qid   busy
        tbl[0]  = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h81, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        tbl[2]  = '{8'h81, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1};
        tbl[3]  = '{8'h81, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        tbl[4]  = '{8'h81, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        tbl[5]  = '{8'h81, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1};
        tbl[6]  = '{8'h81, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1};
        tbl[7]  = '{8'h81, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1};
        tbl[8]  = '{8'h81, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1};
        tbl[9]  = '{8'h81, 1'b1, 1'b0, 1'b1, 3'd0, 1'b1};
        tbl[10] = '{8'h81, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1};
        tbl[11] = '{8'h81, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
        tbl[12] = '{8'h81, 1'b1, 1'b0, 1'b1, 3'd7, 1'b1};
        tbl[13] = '{8'h81, 1'b1, 1'b0, 1'b0, 3'd7, 1'b1};
        tbl[14] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0};
        tbl[15] = '{8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0};

        // Reset state and idle behaviour
        do_reset();
        chk("rst_vld", grant_vld, 0);
        chk("rst_qid", grant_qid, 0);
        chk("rst_busy", busy, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst_weight%0d", i), dut.weight[i], 1);
            chk($sformatf("rst_credit%0d", i), dut.credit[i], 1);
        end
        chk("rst_ptr", dut.ptr, 0);
        step();
        step();
        chk("idle_vld", grant_vld, 0);
        chk("idle_busy", busy, 0);

`ifndef WRR_STRICT_TOP_EN
        // Latency, rotation 0/7 with pointer wrap, reload gap, stray pkt_done
        for (int r = 0; r < 16; r++) begin
            q_nempty  = tbl[r].q;
            grant_rdy = tbl[r].rdy;
            pkt_done  = tbl[r].done;
            step();
            chk($sformatf("tbl%0d_vld", r), grant_vld, tbl[r].exp_vld);
            chk($sformatf("tbl%0d_qid", r), grant_qid, tbl[r].exp_qid);
            chk($sformatf("tbl%0d_busy", r), busy, tbl[r].exp_busy);
        end
        pkt_done = 1'b0;
`endif

        // Weights q0=3, q1=1: first round still on reset credits (1 each)
        do_reset();
        cfg_write(3'd0, 4'd3);
        q_nempty = 8'h03;
        serve(0, "wt_a0");
        serve(1, "wt_a1");
        for (int k = 0; k < 2; k++) begin
            serve(0, $sformatf("wt_r%0d_0", k));
            serve(0, $sformatf("wt_r%0d_1", k));
            serve(0, $sformatf("wt_r%0d_2", k));
            serve(1, $sformatf("wt_r%0d_3", k));
        end

        // Hold: grant stays while sink stalls and the queue empties
        do_reset();
        grant_rdy = 1'b0;
        q_nempty  = 8'h04;
        wait_grant("hold");
        chk("hold_qid0", grant_qid, 2);
        q_nempty = 8'h00;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("hold%0d_vld", k), grant_vld, 1);
            chk($sformatf("hold%0d_qid", k), grant_qid, 2);
        end
        grant_rdy = 1'b1;
        step();
        chk("hold_acc_vld", grant_vld, 0);
        chk("hold_acc_busy", busy, 1);
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
        chk("hold_end_busy", busy, 0);

        // Weight change: q2 disabled while its packet is in flight
        do_reset();
        q_nempty = 8'h06;
        serve(1, "cfg_a");
        wait_grant("cfg_b");
        chk("cfg_b_qid", grant_qid, 2);
        step();
        chk("cfg_b_acc", grant_vld, 0);
        cfg_write(3'd2, 4'd0);
        chk("cfg_b_busy", busy, 1);
        pkt_done = 1'b1;
        step();
        pkt_done = 1'b0;
        for (int k = 0; k < 3; k++)
            serve(1, $sformatf("cfg_off%0d", k));
        // Re-enable q2 with weight 2; the write lands on a reload cycle
        cfg_write(3'd2, 4'd2);
        for (int k = 0; k < 2; k++) begin
            serve(2, $sformatf("cfg_on%0d_0", k));
            serve(2, $sformatf("cfg_on%0d_1", k));
            serve(1, $sformatf("cfg_on%0d_2", k));
        end

        // Asynchronous reset while a grant is pending
        do_reset();
        cfg_write(3'd3, 4'd5);
        grant_rdy = 1'b0;
        q_nempty  = 8'h01;
        wait_grant("arst");
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld", grant_vld, 0);
        chk("arst_busy", busy, 0);
        chk("arst_qid", grant_qid, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        q_nempty  = 8'h00;
        grant_rdy = 1'b1;
        chk("arst_weight3", dut.weight[3], 1);
        step();
        chk("arst_idle_vld", grant_vld, 0);
        chk("arst_idle_busy", busy, 0);

`ifdef WRR_STRICT_TOP_EN
        // Strict top queue beats q0 regardless of pointer and credits
        do_reset();
        q_nempty = 8'h81;
        for (int k = 0; k < 3; k++)
            serve(7, $sformatf("strict%0d", k));
        chk("strict_credit7", dut.credit[7], 1);
        chk("strict_ptr", dut.ptr, 0);
        q_nempty = 8'h01;
        serve(0, "strict_q0");
`endif

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
